fetch_unit: RTL and testbench

//  Parametrised IF stage that supersedes the fixed PC->imem->IF/ID chain.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_unit_if.sv | 38 +++
 rtl/if_id_pipe_reg.sv | 57 +++++
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction fetch (IF) stage:
//     XLEN_DEF / ILEN_DEF : default PC/address and instruction widths
//     NOP_INSTR           : canonical RISC-V NOP (addi x0, x0, 0), placed in
//                           IF/ID whenever the register holds no live instruction
//     fetch_state_t       : fetch FSM encoding
//       BOOT - single idle cycle after reset release
//       REQ  - request outstanding on the instruction memory port
//       HOLD - fetched word parked in the hold buffer while decode stalls
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ILEN_DEF = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Request/acknowledge instruction memory port.
//     req   : fetch request outstanding (driven by the fetch unit)
//     addr  : fetch address, held stable for as long as req is high
//     ack   : rdata is valid this cycle; only meaningful while req is high
//     rdata : fetched instruction word
//   Modports:
//     master : the fetch unit (drives req/addr, samples ack/rdata)
//     slave  : the instruction memory (samples req/addr, drives ack/rdata)
//   A memory may acknowledge in the same cycle req first rises (zero-wait),
//   which yields one instruction per cycle.
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) ();

  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [ILEN-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );

endinterface : fetch_unit_if

// File: rtl/if_id_pipe_reg.sv
// -----------------------------------------------------------------------------
// if_id_pipe_reg
//   IF/ID pipeline register with a valid bit.
//   Ports:
//     i_clk, i_reset  : clock, asynchronous active-high reset
//     i_invalidate    : flush or redirect; empties the register (highest priority)
//     i_load          : capture i_pc / i_instr as a live instruction
//     i_hold          : decode is stalled; keep the current contents
//     i_pc, i_instr   : incoming instruction and its PC
//     o_valid         : register holds a live instruction
//     o_pc, o_instr   : registered PC / instruction (NOP whenever o_valid=0)
//   When nothing is loaded and decode is not stalled, the instruction just
//   consumed by decode is retired and a bubble (valid=0, NOP) takes its
//   place, so decode never sees the same instruction twice.
// -----------------------------------------------------------------------------
module if_id_pipe_reg
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ILEN = ILEN_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_invalidate,
  input  logic            i_load,
  input  logic            i_hold,
  input  logic [XLEN-1:0] i_pc,
  input  logic [ILEN-1:0] i_instr,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [ILEN-1:0] o_instr
);

  localparam logic [ILEN-1:0] NOP = ILEN'(NOP_INSTR);

  // NOTE: state registers use non-blocking assignments so every flop in the
  // design samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_pc    <= '0;
      o_instr <= NOP;
    end else if (i_invalidate) begin
      o_valid <= 1'b0;
      o_instr <= NOP;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_pc    <= i_pc;
      o_instr <= i_instr;
    end else if (!i_hold) begin
      // Decode took the instruction and nothing new arrived: insert a bubble.
      o_valid <= 1'b0;
      o_instr <= NOP;
    end
  end

endmodule : if_id_pipe_reg

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   IF stage of the 5-stage RISC-V pipeline. Fetches from a variable-latency
//   instruction memory over a req/ack port, supports decode stall, IF/ID
//   flush and branch/jump redirect, and drives the IF/ID register.
//   Parameters:
//     XLEN         : PC / address width
//     ILEN         : instruction width
//     RESET_VECTOR : first fetch address after reset
//     PC_STEP      : sequential PC increment
//   Ports:
//     i_clk                   : clock, rising edge
//     i_reset                 : asynchronous, active-high reset
//     i_stall                 : decode cannot accept; hold IF/ID
//     i_flush                 : invalidate IF/ID contents
//     i_redirect_valid        : branch/jump taken this cycle
//     i_redirect_pc           : redirect target
//     imem (master)           : instruction memory req/addr/ack/rdata port
//     o_if_id_valid           : IF/ID holds a live instruction
//     o_if_id_pc_out          : PC of the IF/ID instruction
//     o_if_id_instruction_out : IF/ID instruction (NOP when invalid)
//   Internal state:
//     pc        : architectural next-fetch PC
//     req_addr  : address presented to memory; trails pc only while a killed
//                 request is still waiting for its acknowledge
//     kill      : the outstanding request belongs to a squashed path; its
//                 data is dropped when the ack arrives
//     hold_*    : one-entry buffer for a word that arrived while IF/ID was
//                 full and decode stalled
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter int              ILEN         = ILEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
  parameter int              PC_STEP      = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  fetch_unit_if.master    imem,
  output logic            o_if_id_valid,
  output logic [XLEN-1:0] o_if_id_pc_out,
  output logic [ILEN-1:0] o_if_id_instruction_out
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_addr;
  logic            kill;
  logic [XLEN-1:0] hold_addr;
  logic [ILEN-1:0] hold_data;

  logic [XLEN-1:0] pc_next;
  logic            ack_live;
  logic            if_id_free;
  logic            load_from_mem;
  logic            load_from_hold;
  logic            if_id_load;
  logic [XLEN-1:0] if_id_pc_in;
  logic [ILEN-1:0] if_id_instr_in;

  // Sequential PC; the adder wraps modulo 2^XLEN by construction.
  assign pc_next = pc + XLEN'(PC_STEP);

  // An ack is only honoured while a request is actually outstanding.
  assign ack_live = (state == REQ) && imem.ack;

  // IF/ID can take a new word if decode is moving, or if it only holds a
  // bubble (a stalled bubble is squeezed out rather than preserved).
  assign if_id_free = !i_stall || !o_if_id_valid;

  // A redirect discards whatever would have been delivered this cycle.
  assign load_from_mem  = ack_live && !kill && !i_redirect_valid && if_id_free;
  assign load_from_hold = (state == HOLD) && !i_redirect_valid && if_id_free;

  assign if_id_load     = load_from_mem || load_from_hold;
  assign if_id_pc_in    = (state == HOLD) ? hold_addr : req_addr;
  assign if_id_instr_in = (state == HOLD) ? hold_data : imem.rdata;

  // Memory port: the request and its address come straight from registers,
  // so both are glitch-free and addr is stable for the whole request.
  assign imem.req  = (state == REQ);
  assign imem.addr = req_addr;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= BOOT;
      pc        <= RESET_VECTOR;
      req_addr  <= RESET_VECTOR;
      kill      <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
    end else if (i_redirect_valid) begin
      // Redirect wins over everything else, in every state.
      pc    <= i_redirect_pc;
      state <= REQ;
      if ((state == REQ) && !imem.ack) begin
        // The memory still owns the old request: keep its address stable and
        // discard its data once it finally acknowledges.
        kill <= 1'b1;
      end else begin
        // No request in flight (BOOT/HOLD) or it completes right now: the
        // target can be requested from the next cycle on.
        req_addr <= i_redirect_pc;
        kill     <= 1'b0;
      end
    end else begin
      unique case (state)
        BOOT: begin
          state <= REQ;
        end

        REQ: begin
          if (imem.ack) begin
            if (kill) begin
              // Stale word from a squashed path; start fetching the target.
              kill     <= 1'b0;
              req_addr <= pc;
            end else if (if_id_free) begin
              pc       <= pc_next;
              req_addr <= pc_next;
            end else begin
              hold_addr <= req_addr;
              hold_data <= imem.rdata;
              state     <= HOLD;
            end
          end
        end

        HOLD: begin
          if (if_id_free) begin
            pc       <= pc_next;
            req_addr <= pc_next;
            state    <= REQ;
          end
        end

        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  // Flush and redirect both empty IF/ID and take precedence over stall.
  if_id_pipe_reg #(
    .XLEN (XLEN),
    .ILEN (ILEN)
  ) u_if_id (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_invalidate (i_flush || i_redirect_valid),
    .i_load       (if_id_load),
    .i_hold       (i_stall),
    .i_pc         (if_id_pc_in),
    .i_instr      (if_id_instr_in),
    .o_valid      (o_if_id_valid),
    .o_pc         (o_if_id_pc_out),
    .o_instr      (o_if_id_instruction_out)
  );

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. Two instances: dut (RESET_VECTOR=0) with a
//   memory model of programmable latency, and dut_hi (RESET_VECTOR=FFFF_FFF8)
//   with a zero-wait memory, used for address wrap and mid-request reset.
//   Memory content model: word at address a is ~a.
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        rst_hi;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        if_id_valid,  if_id_valid_hi;
  logic [31:0] if_id_pc,     if_id_pc_hi;
  logic [31:0] if_id_instr,  if_id_instr_hi;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model for dut: ack in the lat-th cycle of each request.
  int lat = 1;
  int cnt;

  fetch_unit_if #(.XLEN(32), .ILEN(32)) bus ();
  fetch_unit_if #(.XLEN(32), .ILEN(32)) bus_hi ();

  assign bus.ack   = bus.req && (cnt >= lat - 1);
  assign bus.rdata = ~bus.addr;

  always @(posedge clk or posedge rst) begin
    if (rst)               cnt <= 0;
    else if (!bus.req)     cnt <= 0;
    else if (bus.ack)      cnt <= 0;
    else                   cnt <= cnt + 1;
  end

  assign bus_hi.ack   = bus_hi.req;
  assign bus_hi.rdata = ~bus_hi.addr;

  fetch_unit #(
    .XLEN(32), .ILEN(32), .RESET_VECTOR(32'h0000_0000), .PC_STEP(4)
  ) dut (
    .i_clk                   (clk),
    .i_reset                 (rst),
    .i_stall                 (stall),
    .i_flush                 (flush),
    .i_redirect_valid        (redirect_valid),
    .i_redirect_pc           (redirect_pc),
    .imem                    (bus),
    .o_if_id_valid           (if_id_valid),
    .o_if_id_pc_out          (if_id_pc),
    .o_if_id_instruction_out (if_id_instr)
  );

  fetch_unit #(
    .XLEN(32), .ILEN(32), .RESET_VECTOR(32'hFFFF_FFF8), .PC_STEP(4)
  ) dut_hi (
    .i_clk                   (clk),
    .i_reset                 (rst_hi),
    .i_stall                 (stall),
    .i_flush                 (flush),
    .i_redirect_valid        (redirect_valid),
    .i_redirect_pc           (redirect_pc),
    .imem                    (bus_hi),
    .o_if_id_valid           (if_id_valid_hi),
    .o_if_id_pc_out          (if_id_pc_hi),
    .o_if_id_instruction_out (if_id_instr_hi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst            = 1'b1;
    rst_hi         = 1'b1;
    stall          = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // ---- Reset state ----
    tick(2);
    check("rst_req",   32'(bus.req),     32'd0);
    check("rst_valid", 32'(if_id_valid), 32'd0);
    check("rst_pc",    if_id_pc,         32'h0);
    check("rst_instr", if_id_instr,      NOP);

    // ---- 1: zero-wait sequential fetch ----
    rst = 1'b0;
    tick();                                   // BOOT -> REQ
    check("t1_req",  32'(bus.req), 32'd1);
    check("t1_addr0", bus.addr,    32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t1_addr",  bus.addr,          32'(4 * (k + 1)));
      check("t1_valid", 32'(if_id_valid),  32'd1);
      check("t1_pc",    if_id_pc,          32'(4 * k));
      check("t1_instr", if_id_instr,       ~32'(4 * k));
      tick();
    end

    // ---- 2: ack latency 3 ----  (req at 0x14, IF/ID holds pc 0x10)
    lat = 3;
    check("t2_addr_c0",  bus.addr,         32'h14);
    check("t2_pc_c0",    if_id_pc,         32'h10);
    tick();
    check("t2_addr_c1",  bus.addr,         32'h14);
    check("t2_bubble1",  32'(if_id_valid), 32'd0);
    check("t2_nop1",     if_id_instr,      NOP);
    tick();
    check("t2_addr_c2",  bus.addr,         32'h14);
    check("t2_bubble2",  32'(if_id_valid), 32'd0);
    tick();
    check("t2_valid",    32'(if_id_valid), 32'd1);
    check("t2_pc",       if_id_pc,         32'h14);
    check("t2_instr",    if_id_instr,      32'hFFFF_FFEB);
    check("t2_addr_nxt", bus.addr,         32'h18);
    lat = 1;
    tick();
    check("t2_pc_nxt",   if_id_pc,         32'h18);

    // ---- 3: stall during ack for 4 cycles ----  (req at 0x1C)
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_req_hold",   32'(bus.req),     32'd0);
      check("t3_valid_hold", 32'(if_id_valid), 32'd1);
      check("t3_pc_hold",    if_id_pc,         32'h18);
      check("t3_instr_hold", if_id_instr,      32'hFFFF_FFE7);
    end
    stall = 1'b0;
    tick();
    check("t3_pc_buf",    if_id_pc,         32'h1C);
    check("t3_instr_buf", if_id_instr,      32'hFFFF_FFE3);
    check("t3_req_back",  32'(bus.req),     32'd1);
    check("t3_addr_back", bus.addr,         32'h20);
    tick();
    check("t3_pc_next",   if_id_pc,         32'h20);

    // ---- 4: redirect while request to 0x8 is outstanding ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(3);
    check("t4_addr8", bus.addr, 32'h8);
    lat            = 3;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("t4_addr_stable1", bus.addr,         32'h8);
    check("t4_valid_r1",     32'(if_id_valid), 32'd0);
    tick();
    check("t4_addr_stable2", bus.addr,         32'h8);
    check("t4_valid_r2",     32'(if_id_valid), 32'd0);
    tick();
    check("t4_addr_target",  bus.addr,         32'h100);
    check("t4_valid_r3",     32'(if_id_valid), 32'd0);
    lat = 1;
    tick();
    check("t4_valid_tgt",    32'(if_id_valid), 32'd1);
    check("t4_pc_tgt",       if_id_pc,         32'h100);
    check("t4_instr_tgt",    if_id_instr,      32'hFFFF_FEFF);

    // zero-wait redirect: req at target N+1, IF/ID valid N+2
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    check("t4z_addr",  bus.addr,         32'h200);
    check("t4z_valid", 32'(if_id_valid), 32'd0);
    tick();
    check("t4z_valid2", 32'(if_id_valid), 32'd1);
    check("t4z_pc",     if_id_pc,         32'h200);

    // ---- 5: simultaneous stall + flush ----  (req at 0x204)
    stall = 1'b1;
    flush = 1'b1;
    tick();
    stall = 1'b0;
    flush = 1'b0;
    check("t5_valid", 32'(if_id_valid), 32'd0);
    check("t5_nop",   if_id_instr,      NOP);
    tick();
    check("t5_valid_cont", 32'(if_id_valid), 32'd1);
    check("t5_pc_cont",    if_id_pc,         32'h204);
    check("t5_instr_cont", if_id_instr,      32'hFFFF_FDFB);
    check("t5_addr_cont",  bus.addr,         32'h208);

    // ---- 6: reset vector near top of address space, wrap, mid reset ----
    rst_hi = 1'b0;
    tick();
    check("t6_addr0", bus_hi.addr, 32'hFFFF_FFF8);
    tick();
    check("t6_addr1", bus_hi.addr, 32'hFFFF_FFFC);
    check("t6_pc0",   if_id_pc_hi, 32'hFFFF_FFF8);
    tick();
    check("t6_addr_wrap", bus_hi.addr,    32'h0);
    check("t6_pc1",       if_id_pc_hi,    32'hFFFF_FFFC);
    check("t6_instr1",    if_id_instr_hi, 32'h0000_0003);
    #3;
    rst_hi = 1'b1;
    #1;
    check("t6_rst_req",   32'(bus_hi.req),     32'd0);
    check("t6_rst_valid", 32'(if_id_valid_hi), 32'd0);
    check("t6_rst_instr", if_id_instr_hi,      NOP);
    check("t6_rst_pc",    if_id_pc_hi,         32'h0);
    tick();
    check("t6_rst_addr",  bus_hi.addr,         32'hFFFF_FFF8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit
